// File: rtl/qam_serial_demod.sv
// Bit-serial QAM receiver: deframes LSB-first 8-bit samples, correlates against a 4-phase I/Q carrier, slices 2-bit symbols.
// Define QAM_RX_ERR_COUNT_EN to build the saturating framing-error counter; otherwise error_count is tied to zero.
module qam_serial_demod #(
    parameter int SYM_SAMPLES = 8,
    parameter int ACC_W       = 8 + $clog2(SYM_SAMPLES) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_bit_in,
    input  logic       data_in_complete_bit,
    output logic [7:0] sample_out,
    output logic       sample_valid,
    output logic [1:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic [7:0] error_count
);

    localparam int SYM_W = $clog2(SYM_SAMPLES);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_SAMPLES - 1);

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] sample_out_q, sample_out_d;
    logic       sample_valid_q, sample_valid_d;
    logic       frame_error_q, frame_error_d;

    logic             sample_accept;
    logic             frame_err;

    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] acc_i_sum, acc_q_sum;
    logic signed [ACC_W-1:0] s_ext;
    logic [1:0]              phase_q, phase_d;
    logic [SYM_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [1:0]              data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;

    // ---------------- deframer FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- deframer FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: if (data_in_complete_bit) state_d = SYNC;
            SYNC: if (bit_cnt_q == 3'd7 && !data_in_complete_bit) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // ---------------- deframer FSM: outputs / bit assembly ----------------
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        sample_accept = 1'b0;
        frame_err     = 1'b0;
        if (state_q == SYNC) begin
            shreg_d[bit_cnt_q] = data_bit_in;
            if (bit_cnt_q == 3'd7) begin
                bit_cnt_d = 3'd0;
                if (data_in_complete_bit) begin
                    sample_accept = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
            end else if (data_in_complete_bit) begin
                // Early marker: drop the partial byte and realign on the next bit.
                frame_err = 1'b1;
                bit_cnt_d = 3'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end else begin
            bit_cnt_d = 3'd0;
        end

        sample_out_d   = sample_accept ? shreg_d : sample_out_q;
        sample_valid_d = sample_accept;
        frame_error_d  = frame_err;
    end

    // ---------------- correlator and slicer ----------------
    always_comb begin
        s_ext     = {{(ACC_W-8){sample_out_q[7]}}, sample_out_q};
        acc_i_sum = acc_i_q;
        acc_q_sum = acc_q_q;
        case (phase_q)
            2'd0:    acc_i_sum = acc_i_q + s_ext;
            2'd1:    acc_q_sum = acc_q_q + s_ext;
            2'd2:    acc_i_sum = acc_i_q - s_ext;
            default: acc_q_sum = acc_q_q - s_ext;
        endcase
    end

    // The registered sample feeds the correlator one edge after acceptance,
    // which puts data_valid one cycle behind the symbol's last sample_valid.
    always_comb begin
        acc_i_d      = acc_i_q;
        acc_q_d      = acc_q_q;
        phase_d      = phase_q;
        sym_cnt_d    = sym_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        if (frame_err) begin
            acc_i_d   = '0;
            acc_q_d   = '0;
            phase_d   = 2'd0;
            sym_cnt_d = '0;
        end else if (sample_valid_q) begin
            if (sym_cnt_q == SYM_LAST) begin
                data_out_d   = {acc_i_sum[ACC_W-1], acc_q_sum[ACC_W-1]};
                data_valid_d = 1'b1;
                acc_i_d      = '0;
                acc_q_d      = '0;
                phase_d      = 2'd0;
                sym_cnt_d    = '0;
            end else begin
                acc_i_d   = acc_i_sum;
                acc_q_d   = acc_q_sum;
                phase_d   = phase_q + 2'd1;
                sym_cnt_d = sym_cnt_q + SYM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q      <= 3'd0;
            shreg_q        <= 8'd0;
            sample_out_q   <= 8'd0;
            sample_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
            acc_i_q        <= '0;
            acc_q_q        <= '0;
            phase_q        <= 2'd0;
            sym_cnt_q      <= '0;
            data_out_q     <= 2'd0;
            data_valid_q   <= 1'b0;
        end else begin
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            frame_error_q  <= frame_error_d;
            acc_i_q        <= acc_i_d;
            acc_q_q        <= acc_q_d;
            phase_q        <= phase_d;
            sym_cnt_q      <= sym_cnt_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
        end
    end

    // ---------------- framing-error counter ----------------
`ifdef QAM_RX_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign error_count = err_cnt_q;
`else
    assign error_count = 8'd0;
`endif

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_qam_serial_demod.sv
// Directed bench for qam_serial_demod: framing, symbol slicing, misframe handling and asynchronous reset.
module tb_qam_serial_demod;

`ifdef QAM_RX_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_bit_in = 1'b0;
    logic       data_in_complete_bit = 1'b0;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic [1:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic [7:0] error_count;

    int errors = 0;
    int checks = 0;

    int        cyc = 0;
    int        sv_cnt = 0;
    int        dv_cnt = 0;
    int        fe_cnt = 0;
    int        coinc = 0;
    int        last_sv_cyc = 0;
    int        dv_lat = 0;
    logic [7:0] last_sample = 8'd0;
    logic [1:0] last_dout = 2'd0;

    logic [7:0] pat [4][4];
    logic [1:0] exp_sym [4];

    qam_serial_demod dut (
        .clk                  (clk),
        .rst                  (rst),
        .data_bit_in          (data_bit_in),
        .data_in_complete_bit (data_in_complete_bit),
        .sample_out           (sample_out),
        .sample_valid         (sample_valid),
        .data_out             (data_out),
        .data_valid           (data_valid),
        .frame_error          (frame_error),
        .error_count          (error_count)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (sample_valid) begin
            sv_cnt      = sv_cnt + 1;
            last_sv_cyc = cyc;
            last_sample = sample_out;
        end
        if (data_valid) begin
            dv_cnt    = dv_cnt + 1;
            last_dout = data_out;
            dv_lat    = cyc - last_sv_cyc;
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (frame_error && sample_valid) coinc = coinc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks = checks + 1;
        assert (obs === exp_v) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one byte LSB first; complete marker on bit index cpos (-1 = none).
    task automatic send_byte(input logic [7:0] b, input int cpos);
        for (int i = 0; i < 8; i++) begin
            data_bit_in          = b[i];
            data_in_complete_bit = (i == cpos);
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sample_out"},   {24'd0, sample_out},   32'd0);
        check({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
        check({tag, "_data_out"},     {30'd0, data_out},     32'd0);
        check({tag, "_data_valid"},   {31'd0, data_valid},   32'd0);
        check({tag, "_frame_error"},  {31'd0, frame_error},  32'd0);
        check({tag, "_error_count"},  {24'd0, error_count},  32'd0);
    endtask

    initial begin
        int sv_base;
        int dv_base;

        pat[0] = '{8'h40, 8'h00, 8'hC0, 8'h00};  exp_sym[0] = 2'b00;
        pat[1] = '{8'hC0, 8'h00, 8'h40, 8'h00};  exp_sym[1] = 2'b10;
        pat[2] = '{8'h00, 8'hC0, 8'h00, 8'h40};  exp_sym[2] = 2'b01;
        pat[3] = '{8'hC0, 8'hC0, 8'h40, 8'h40};  exp_sym[3] = 2'b11;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Marker, then 0x5A
        data_bit_in = 1'b0;
        data_in_complete_bit = 1'b1;
        @(negedge clk);
        send_byte(8'h5A, 7);
        check("first_sv_cnt", sv_cnt, 1);
        check("first_sample", {24'd0, last_sample}, 32'h5A);
        check("first_no_fe", fe_cnt, 0);

        // Early marker on bit 4
        for (int i = 0; i < 5; i++) begin
            data_bit_in          = 1'b1;
            data_in_complete_bit = (i == 4);
            @(negedge clk);
        end
        check("early_fe_cnt", fe_cnt, 1);
        check("early_no_sv", sv_cnt, 1);

        // Four symbols; each is checked after the next one's first sample
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                send_byte(pat[s][k % 4], 7);
                if (k == 0 && s > 0) begin
                    check("sym_dv_cnt", dv_cnt, s);
                    check("sym_data_out", {30'd0, last_dout}, {30'd0, exp_sym[s-1]});
                    check("sym_dv_latency", dv_lat, 1);
                end
            end
        end
        check("realign_sample", {24'd0, last_sample}, 32'h40);

        // Missing marker on bit 7 -> error, HUNT
        send_byte(8'h00, -1);
        check("sym4_dv_cnt", dv_cnt, 4);
        check("sym4_data_out", {30'd0, last_dout}, 32'd3);
        check("sym4_dv_latency", dv_lat, 1);
        check("missing_fe_cnt", fe_cnt, 2);
        check("total_sv_cnt", sv_cnt, 33);
        check("err_count_2", {24'd0, error_count}, ERR_EN ? 32'd2 : 32'd0);

        // In HUNT, unmarked bytes are ignored
        send_byte(8'hFF, -1);
        send_byte(8'h81, -1);
        check("hunt_fe_cnt", fe_cnt, 2);
        check("hunt_sv_cnt", sv_cnt, 33);

        // 300 back-to-back misframes
        data_bit_in = 1'b0;
        data_in_complete_bit = 1'b1;
        @(negedge clk);
        repeat (300) @(negedge clk);
        check("burst_fe_cnt", fe_cnt, 302);
        check("err_count_sat", {24'd0, error_count}, ERR_EN ? 32'd255 : 32'd0);
        send_byte(8'h40, 7);
        check("resync_sv_cnt", sv_cnt, 34);
        check("resync_sample", {24'd0, last_sample}, 32'h40);

        // Reset during bit 3 of sample 5 of a symbol
        repeat (4) send_byte(8'h40, 7);
        for (int i = 0; i < 3; i++) begin
            data_bit_in          = 1'b1;
            data_in_complete_bit = 1'b0;
            @(negedge clk);
        end
        data_bit_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        sv_base = sv_cnt;
        dv_base = dv_cnt;

        send_byte(8'h40, -1);
        send_byte(8'hC0, -1);
        check("postrst_no_sv", sv_cnt, sv_base);

        data_bit_in = 1'b0;
        data_in_complete_bit = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            send_byte(pat[3][k % 4], 7);
            if (k == 6) check("postrst_no_early_dv", dv_cnt, dv_base);
        end
        data_bit_in = 1'b0;
        data_in_complete_bit = 1'b0;
        @(negedge clk);
        check("postrst_dv_cnt", dv_cnt, dv_base + 1);
        check("postrst_data_out", {30'd0, last_dout}, 32'd3);
        check("postrst_sv_cnt", sv_cnt, sv_base + 8);
        check("postrst_err_count", {24'd0, error_count}, 32'd0);
        check("fe_sv_coincident", coinc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
